// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle add/sub/slt, optional multi-cycle shift-add multiply.
// Define ALU_MUL_EN to build the MUL state and multiply datapath; otherwise 101 acts as an undefined code.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// MUL   | shift-add multiply in flight, one iteration per edge (ALU_MUL_EN only)
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALUCtrl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b110;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] single_res;
    logic             done_q, done_d;
    logic             slt_bit;

    assign slt_bit = $signed(SrcA) < $signed(SrcB);

    always_comb begin
        single_res = '0;
        case (ALUCtrl)
            OP_ADD:  single_res = SrcA + SrcB;
            OP_SUB:  single_res = SrcA - SrcB;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: single_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The final iteration's add is folded straight into the result write.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUCtrl == OP_MUL) begin
                        state_d  = MUL;
                        mcand_d  = SrcA;
                        mplier_d = SrcB;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        result_d = single_res;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = acc_step;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == MUL);
`else
    always_comb begin
        result_d = result_q;
        done_d   = 1'b0;
        if (start) begin
            result_d = single_res;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy = 1'b0;
`endif

    assign ALUResult = result_q;
    assign done      = done_q;
    assign Zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: random and directed ops against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 32;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   ALUCtrl;
    logic [W-1:0] SrcA, SrcB;
    logic [W-1:0] ALUResult;
    logic         Zero, busy, done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUCtrl(ALUCtrl),
        .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult),
        .Zero(Zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            3'b010: return a + b;
            3'b100: return a - b;
            3'b110: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'b101: begin
                if (MUL_EN) begin
                    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    return p[W-1:0];
                end
                return '0;
            end
            default: return '0;
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result", ALUResult, e.res);
                chk("zero", Zero, (e.res == '0));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n;
        start = 1'b1; ALUCtrl = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        e.res = model(op, a, b);
        if (MUL_EN && op == 3'b101) begin
            e.cyc = cyc + W;
            sb.push_back(e);
            n = 0;
            // Hammer start and operands while busy; none of it may disturb the product.
            while (busy && n < 100) begin
                start   = 1'($urandom_range(0, 1));
                ALUCtrl = 3'($urandom);
                SrcA    = $urandom;
                SrcB    = $urandom;
                @(posedge clk); #1;
                n++;
            end
            start = 1'b0;
            chk("mul_busy_cycles", n, W);
        end else begin
            e.cyc = cyc;
            sb.push_back(e);
            start = 1'b0;
            chk("busy_single", busy, 0);
        end
    endtask

    initial begin
        logic [2:0] op;
        logic [W-1:0] a, b;
        int r;

        rst = 1'b1; start = 1'b0; ALUCtrl = 3'b000; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", ALUResult, 0);
        chk("rst_zero", Zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b1; ALUCtrl = 3'b010; SrcA = 1; SrcB = 1;
        @(posedge clk); #1;
        chk("rst_over_start", done, 0);
        start = 1'b0;
        rst = 1'b0;

        do_op(3'b010, 5, 7);
        do_op(3'b110, 32'hFFFF_FFFF, 1);
        do_op(3'b100, 3, 3);
        do_op(3'b111, 32'h1234, 32'h5678);
        do_op(3'b101, 32'h0001_0001, 32'h0001_0001);
        do_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'b101, 6, 7);
        chk("busy_after_101", busy, 0);
        do_op(3'b010, 32'hFFFF_FFFF, 1);
        do_op(3'b110, 1, 32'hFFFF_FFFF);
        do_op(3'b110, 32'h8000_0000, 32'h7FFF_FFFF);

        do_op(3'b010, 100, 23);
        @(posedge clk); #1;
        if (MUL_EN) begin
            start = 1'b1; ALUCtrl = 3'b101; SrcA = 32'hABCD; SrcB = 32'h1234;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (10) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_result", ALUResult, 0);
        chk("midrst_done", done, 0);
        chk("midrst_zero", Zero, 1);
        repeat (3) @(posedge clk);
        #1;
        do_op(3'b010, 1, 1);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: op = 3'b010;
                1: op = 3'b100;
                2: op = 3'b110;
                3: op = 3'b101;
                default: op = 3'($urandom);
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 15));
            do_op(op, a, b);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
